// File: rtl/obc_dft_slice_sequencer.sv
// Frame buffer, bit-slice sequencer and shift-accumulator for one OBC distributed-arithmetic DFT bin.
// Optional build macro OBC_DFT_SEQ_ROUND_EN selects round-half-up shifts instead of truncating shifts.
module obc_dft_slice_sequencer #(
  parameter int NPTS = 16,
  parameter int SW = 12,
  parameter int DW = 32,
  parameter logic [DW-1:0] OFFSET = '0,
  localparam int JW = (SW > 1) ? $clog2(SW) : 1,
  localparam int CW = (NPTS > 1) ? $clog2(NPTS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_data,
  output logic [NPTS-1:0] slice,
  output logic          slice_valid,
  output logic [JW-1:0] slice_idx,
  input  logic [DW-1:0] rom_re,
  input  logic [DW-1:0] rom_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_re/out_im hold stable while out_valid is high.

  typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;

  state_t state, state_nxt;

  logic [SW-1:0] samples_q [NPTS];
  logic [CW-1:0] count;
  logic [JW-1:0] j;
  logic signed [DW-1:0] acc_re, acc_im;
  logic signed [DW-1:0] sh_re, sh_im, acc_re_nxt, acc_im_nxt;
  logic last_sample, last_slice, accept;

  assign last_sample = (count == CW'(NPTS - 1));
  assign last_slice  = (j == JW'(SW - 1));
  assign accept      = in_valid && in_ready;

  assign in_ready    = rst_n && (state == LOAD);
  assign slice_valid = (state == COMPUTE);
  assign slice_idx   = (state == COMPUTE) ? j : '0;
  assign busy        = (state == COMPUTE) || (state == DONE);

  always_comb begin
    slice = '0;
    if (state == COMPUTE) begin
      for (int k = 0; k < NPTS; k++) slice[k] = samples_q[k][j];
    end
  end

`ifdef OBC_DFT_SEQ_ROUND_EN
  assign sh_re = (acc_re >>> 1) + DW'(acc_re[0]);
  assign sh_im = (acc_im >>> 1) + DW'(acc_im[0]);
`else
  assign sh_re = acc_re >>> 1;
  assign sh_im = acc_im >>> 1;
`endif

  // The last slice carries the sample sign bits, so its weight is negative.
  assign acc_re_nxt = last_slice ? sh_re - $signed(rom_re) : sh_re + $signed(rom_re);
  assign acc_im_nxt = last_slice ? sh_im - $signed(rom_im) : sh_im + $signed(rom_im);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && last_sample) state_nxt = COMPUTE;
      COMPUTE: if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // The sample buffer needs no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == LOAD && accept) samples_q[count] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      j         <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            count <= last_sample ? '0 : count + CW'(1);
            if (last_sample) begin
              j      <= '0;
              acc_re <= '0;
              acc_im <= '0;
            end
          end
        end
        COMPUTE: begin
          acc_re <= acc_re_nxt;
          acc_im <= acc_im_nxt;
          if (last_slice) begin
            j         <= '0;
            out_re    <= acc_re_nxt + OFFSET;
            out_im    <= acc_im_nxt + OFFSET;
            out_valid <= 1'b1;
          end else begin
            j <= j + JW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            count     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obc_dft_slice_sequencer.sv
// Directed bench for obc_dft_slice_sequencer with SW=4: slice order, accumulation, handshake, throttling, mid-frame reset.
module tb_obc_dft_slice_sequencer;

  localparam int NPTS = 16;
  localparam int SW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [SW-1:0] in_data = '0;
  logic [NPTS-1:0] slice;
  logic slice_valid;
  logic [1:0] slice_idx;
  logic [DW-1:0] rom_re, rom_im;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_re, out_im;
  logic busy;
  logic rom_mode = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  obc_dft_slice_sequencer #(.NPTS(NPTS), .SW(SW), .DW(DW), .OFFSET(32'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .slice(slice), .slice_valid(slice_valid), .slice_idx(slice_idx),
    .rom_re(rom_re), .rom_im(rom_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .busy(busy)
  );

  // ROM stand-in: mode 0 gives constant words, mode 1 feeds the slice back as the real word.
  always_comb begin
    if (rom_mode) begin
      rom_re = {16'h0000, slice};
      rom_im = 32'd5;
    end else begin
      rom_re = 32'd5;
      rom_im = 32'hFFFF_FFFD;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic load_frame(input bit rev, input bit thr);
    for (int k = 0; k < NPTS; k++) begin
      if (thr) begin
        in_valid = 1'b0;
        in_data  = 4'hF;
        @(posedge clk); #1;
        if (k == NPTS - 1) begin
          check("thr_busy_before_16th", busy, 0);
          check("thr_in_ready_idle", in_ready, 1);
        end
      end
      in_valid = 1'b1;
      in_data  = rev ? 4'(15 - k) : 4'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Called one step after the edge that took the 16th sample; walks all four slices.
  task automatic run_compute(input logic [63:0] slices, input logic [31:0] exp_re, input logic [31:0] exp_im);
    for (int j = 0; j < SW; j++) begin
      check("slice", slice, slices[16*j +: 16]);
      check("slice_idx", slice_idx, j);
      check("slice_valid", slice_valid, 1);
      check("out_valid_compute", out_valid, 0);
      check("in_ready_compute", in_ready, 0);
      @(posedge clk); #1;
    end
    check("out_valid_done", out_valid, 1);
    check("out_re", out_re, exp_re);
    check("out_im", out_im, exp_im);
    check("slice_valid_done", slice_valid, 0);
    check("slice_done", slice, 0);
    check("busy_done", busy, 1);
  endtask

  task automatic ack;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_ack", out_valid, 0);
    check("in_ready_after_ack", in_ready, 1);
    check("busy_after_ack", busy, 0);
  endtask

`ifdef OBC_DFT_SEQ_ROUND_EN
  localparam logic [31:0] A_RE = 32'h0000_0000, A_IM = 32'h0000_0001;
  localparam logic [31:0] B_RE = 32'h0000_1E00, B_IM = 32'h0000_0000;
  localparam logic [31:0] D_RE = 32'hFFFF_C201, D_IM = 32'h0000_0000;
`else
  localparam logic [31:0] A_RE = 32'hFFFF_FFFF, A_IM = 32'h0000_0000;
  localparam logic [31:0] B_RE = 32'h0000_1DFF, B_IM = 32'hFFFF_FFFF;
  localparam logic [31:0] D_RE = 32'hFFFF_C200, D_IM = 32'hFFFF_FFFF;
`endif

  initial begin
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_slice_valid", slice_valid, 0);
    check("rst_slice", slice, 0);
    check("rst_slice_idx", slice_idx, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Frame A: samples 0..15, constant ROM words 5 / -3.
    rom_mode = 1'b0;
    load_frame(1'b0, 1'b0);
    run_compute({16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA}, A_RE, A_IM);

    // Result must hold while the consumer stalls; input pulses are ignored.
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_data  = 4'h7;
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_out_re", out_re, A_RE);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ack();

    // Frame B: reversed samples, throttled source, slice-dependent ROM.
    rom_mode = 1'b1;
    load_frame(1'b1, 1'b1);
    run_compute({16'h00FF, 16'h0F0F, 16'h3333, 16'h5555}, B_RE, B_IM);
    ack();

    // Frame C: aborted by reset at j=2.
    load_frame(1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_slice_idx_pre", slice_idx, 2);
    rst_n = 1'b0;
    #1;
    check("abort_slice_valid", slice_valid, 0);
    check("abort_slice", slice, 0);
    check("abort_slice_idx", slice_idx, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst_n = 1'b1;
      check("abort_no_out_valid", out_valid, 0);
    end
    check("abort_out_re", out_re, 0);

    // Frame D: full frame after the abort.
    load_frame(1'b0, 1'b0);
    run_compute({16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA}, D_RE, D_IM);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
